// File: rtl/mic4_pulse_seq_if.sv
// mic4_pulse_seq_if: command/config bus plus controller-facing outputs of the MIC4 pulse sequencer.
// Latency: none (wires only).
// Backpressure: none; the sequencer ignores start while busy.
//
// Ports (master = software/command side, slave = sequencer):
//   start, abort             single-cycle command strobes
//   cfg_*                    sequence configuration, sampled with start
//   div0, div1               latched divider settings for the controller
//   pulse_grst/_a/_d         single-cycle requests for the controller
//   busy, done, rep_cnt      sequence status
interface mic4_pulse_seq_if #(
  parameter int DIV_WIDTH = 6,
  parameter int CNT_WIDTH = 16,
  parameter int REP_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic [DIV_WIDTH-1:0] cfg_div0;
  logic [DIV_WIDTH-1:0] cfg_div1;
  logic                 cfg_en_grst;
  logic                 cfg_en_a;
  logic                 cfg_en_d;
  logic [CNT_WIDTH-1:0] cfg_grst_gap;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [REP_WIDTH-1:0] cfg_nrep;

  logic [DIV_WIDTH-1:0] div0;
  logic [DIV_WIDTH-1:0] div1;
  logic                 pulse_grst;
  logic                 pulse_a;
  logic                 pulse_d;
  logic                 busy;
  logic                 done;
  logic [REP_WIDTH-1:0] rep_cnt;

  modport master (
    output start, abort, cfg_div0, cfg_div1, cfg_en_grst, cfg_en_a, cfg_en_d,
           cfg_grst_gap, cfg_period, cfg_nrep,
    input  div0, div1, pulse_grst, pulse_a, pulse_d, busy, done, rep_cnt
  );

  modport slave (
    input  start, abort, cfg_div0, cfg_div1, cfg_en_grst, cfg_en_a, cfg_en_d,
           cfg_grst_gap, cfg_period, cfg_nrep,
    output div0, div1, pulse_grst, pulse_a, pulse_d, busy, done, rep_cnt
  );
endinterface

// File: rtl/mic4_pulse_seq.sv
// mic4_pulse_seq: turns one start command into divider settings, an optional grst strobe and N injection strobes.
// Latency: div0/div1 and busy update 1 cycle after start; first strobe SETTLE_CYCLES+1 cycles after start.
// Backpressure: none; start is ignored while busy, abort cancels at once (strobes masked in the abort cycle).
//
// Ports:
//   clk_control  100 MHz control clock, sole clock
//   rst          synchronous active-high reset
//   ext_trig     (only with MIC4_PULSE_SEQ_TRIG_EN) asynchronous injection trigger
//   bus          mic4_pulse_seq_if slave modport: start/abort/cfg_* in, div/pulse/status out
//
// Optional feature macro: MIC4_PULSE_SEQ_TRIG_EN. When defined, injections are paced by
// synchronized rising edges of ext_trig instead of cfg_period (WAIT becomes WAIT_TRIG).
// SETTLE always lasts at least one cycle, even with SETTLE_CYCLES=0.
module mic4_pulse_seq #(
  parameter int DIV_WIDTH     = 6,
  parameter int CNT_WIDTH     = 16,
  parameter int REP_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic            clk_control,
  input  logic            rst,
`ifdef MIC4_PULSE_SEQ_TRIG_EN
  input  logic            ext_trig,
`endif
  mic4_pulse_seq_if.slave bus
);

`ifdef MIC4_PULSE_SEQ_TRIG_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_GRST, ST_GAP, ST_INJ, ST_WAIT_TRIG, ST_DONE
  } state_t;
  // The first injection also waits for a trigger edge, so it issues no strobe on entry.
  localparam state_t FIRST_INJ    = ST_WAIT_TRIG;
  localparam logic   FIRST_IS_INJ = 1'b0;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_GRST, ST_GAP, ST_INJ, ST_WAIT, ST_DONE
  } state_t;
  localparam state_t FIRST_INJ    = ST_INJ;
  localparam logic   FIRST_IS_INJ = 1'b1;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LIM = CNT_WIDTH'(SETTLE_CYCLES);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt_q;        // cycles spent in SETTLE/GAP/WAIT, 1 on entry

  // Shadow copies of the configuration, frozen at start.
  logic                 en_grst_q;
  logic                 en_a_q;
  logic                 en_d_q;
  logic [CNT_WIDTH-1:0] gap_q;
  logic [REP_WIDTH-1:0] nrep_q;

  // Registered outputs.
  logic [DIV_WIDTH-1:0] div0_q;
  logic [DIV_WIDTH-1:0] div1_q;
  logic                 pulse_grst_q;
  logic                 pulse_a_q;
  logic                 pulse_d_q;
  logic                 busy_q;
  logic                 done_q;
  logic [REP_WIDTH-1:0] rep_cnt_q;

  // Only evaluated in INJ, where nrep_q is non-zero, so the subtraction cannot underflow.
  logic last_inj;
  assign last_inj = (rep_cnt_q >= nrep_q - REP_WIDTH'(1));

`ifdef MIC4_PULSE_SEQ_TRIG_EN
  logic trig_s1, trig_s2, trig_s3;
  logic trig_rise;

  // Two flops to resynchronize ext_trig, a third to find its rising edge.
  always_ff @(posedge clk_control) begin
    if (rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
    end else begin
      trig_s1 <= ext_trig;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end

  assign trig_rise = trig_s2 & ~trig_s3;
`else
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] wait_len;

  // WAIT length giving an INJ-to-INJ spacing of max(p,2): the controller needs a low
  // cycle between strobes to see each one as a separate edge.
  assign wait_len = (period_q < CNT_WIDTH'(2)) ? CNT_ONE : period_q - CNT_ONE;
`endif

  always_ff @(posedge clk_control) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt_q        <= '0;
      en_grst_q    <= 1'b0;
      en_a_q       <= 1'b0;
      en_d_q       <= 1'b0;
      gap_q        <= '0;
      nrep_q       <= '0;
`ifndef MIC4_PULSE_SEQ_TRIG_EN
      period_q     <= '0;
`endif
      div0_q       <= '0;
      div1_q       <= '0;
      pulse_grst_q <= 1'b0;
      pulse_a_q    <= 1'b0;
      pulse_d_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rep_cnt_q    <= '0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      pulse_grst_q <= 1'b0;
      pulse_a_q    <= 1'b0;
      pulse_d_q    <= 1'b0;
      done_q       <= 1'b0;

      case (state)
        ST_IDLE: begin
          // abort in the same cycle as start wins.
          if (bus.start && !bus.abort) begin
            en_grst_q <= bus.cfg_en_grst;
            en_a_q    <= bus.cfg_en_a;
            en_d_q    <= bus.cfg_en_d;
            gap_q     <= bus.cfg_grst_gap;
            nrep_q    <= bus.cfg_nrep;
`ifndef MIC4_PULSE_SEQ_TRIG_EN
            period_q  <= bus.cfg_period;
`endif
            div0_q    <= bus.cfg_div0;
            div1_q    <= bus.cfg_div1;
            rep_cnt_q <= '0;
            busy_q    <= 1'b1;
            cnt_q     <= CNT_ONE;
            state     <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          if (bus.abort) begin
            // div0/div1 and rep_cnt keep their values; only the sequence stops.
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt_q  <= '0;
          end else begin
            case (state)
              ST_SETTLE: begin
                if (cnt_q >= SETTLE_LIM) begin
                  cnt_q <= CNT_ONE;
                  if (en_grst_q) begin
                    state        <= ST_GRST;
                    pulse_grst_q <= 1'b1;
                  end else if (nrep_q != '0) begin
                    state     <= FIRST_INJ;
                    pulse_a_q <= FIRST_IS_INJ & en_a_q;
                    pulse_d_q <= FIRST_IS_INJ & en_d_q;
                  end else begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                  end
                end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                end
              end

              ST_GRST: begin
                cnt_q <= CNT_ONE;
                if (nrep_q == '0) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                end else if (gap_q == '0) begin
                  // Zero gap: first injection in the cycle right after grst.
                  state     <= FIRST_INJ;
                  pulse_a_q <= FIRST_IS_INJ & en_a_q;
                  pulse_d_q <= FIRST_IS_INJ & en_d_q;
                end else begin
                  state <= ST_GAP;
                end
              end

              ST_GAP: begin
                if (cnt_q >= gap_q) begin
                  state     <= FIRST_INJ;
                  pulse_a_q <= FIRST_IS_INJ & en_a_q;
                  pulse_d_q <= FIRST_IS_INJ & en_d_q;
                end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                end
              end

              ST_INJ: begin
                // Saturate at N so the count never passes the requested number.
                rep_cnt_q <= last_inj ? nrep_q : rep_cnt_q + REP_WIDTH'(1);
                cnt_q     <= CNT_ONE;
                if (last_inj) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                end else begin
`ifdef MIC4_PULSE_SEQ_TRIG_EN
                  state <= ST_WAIT_TRIG;
`else
                  state <= ST_WAIT;
`endif
                end
              end

`ifdef MIC4_PULSE_SEQ_TRIG_EN
              ST_WAIT_TRIG: begin
                if (trig_rise) begin
                  state     <= ST_INJ;
                  pulse_a_q <= en_a_q;
                  pulse_d_q <= en_d_q;
                end
              end
`else
              ST_WAIT: begin
                if (cnt_q >= wait_len) begin
                  state     <= ST_INJ;
                  pulse_a_q <= en_a_q;
                  pulse_d_q <= en_d_q;
                end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                end
              end
`endif

              default: begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.div0       = div0_q;
  assign bus.div1       = div1_q;
  // Strobes are already registered for this cycle; masking with abort keeps them
  // silent from the abort cycle onward.
  assign bus.pulse_grst = pulse_grst_q & ~bus.abort;
  assign bus.pulse_a    = pulse_a_q & ~bus.abort;
  assign bus.pulse_d    = pulse_d_q & ~bus.abort;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rep_cnt    = rep_cnt_q;

endmodule

// File: tb/tb_mic4_pulse_seq.sv
// tb_mic4_pulse_seq: directed checks of mic4_pulse_seq sequence timing, abort, reset and config shadowing.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mic4_pulse_seq;
  localparam int DW = 6;
  localparam int CW = 16;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef MIC4_PULSE_SEQ_TRIG_EN
  logic ext_trig;
`endif

  mic4_pulse_seq_if #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .REP_WIDTH(RW)) bus ();

  mic4_pulse_seq #(
    .DIV_WIDTH(DW), .CNT_WIDTH(CW), .REP_WIDTH(RW), .SETTLE_CYCLES(8)
  ) dut (
    .clk_control(clk),
    .rst        (rst),
`ifdef MIC4_PULSE_SEQ_TRIG_EN
    .ext_trig   (ext_trig),
`endif
    .bus        (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Mask with bits lo..hi set (cycle ranges).
  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] at(input int c);
    return 64'd1 << c;
  endfunction

  // Per-cycle activity of one run, bit k = cycle k (cycle 0 = start cycle).
  logic [63:0] m_grst, m_a, m_d, m_done, m_busy;
  logic [DW-1:0] div0_c1, div1_c1, div0_end, div1_end;
  logic [RW-1:0] rep_c16, rep_end;

  task automatic set_cfg(input logic g_en, input logic a_en, input logic d_en,
                         input int gap, input int per, input int n,
                         input int d0, input int d1);
    bus.cfg_en_grst  = g_en;
    bus.cfg_en_a     = a_en;
    bus.cfg_en_d     = d_en;
    bus.cfg_grst_gap = CW'(gap);
    bus.cfg_period   = CW'(per);
    bus.cfg_nrep     = RW'(n);
    bus.cfg_div0     = DW'(d0);
    bus.cfg_div1     = DW'(d1);
  endtask

  // Start at cycle 0, optional second start / abort / reset at given cycles (-1 = none).
  // Config is scrambled at cycle 1 so any use of live cfg_* shows up.
  task automatic run_seq(input int ncyc, input int start2, input int abort_c, input int rst_c);
    m_grst = '0; m_a = '0; m_d = '0; m_done = '0; m_busy = '0;
    div0_c1 = '0; div1_c1 = '0; rep_c16 = '0;
    @(posedge clk); #1;
    for (int k = 0; k < ncyc; k++) begin
      bus.start = (k == 0) || (k == start2);
      bus.abort = (k == abort_c);
      rst       = (k == rst_c);
      if (k == 1) set_cfg(1'b0, 1'b0, 1'b0, 1, 3, 1, 63, 0);
`ifdef MIC4_PULSE_SEQ_TRIG_EN
      ext_trig = (k >= 30 && k < 33) || (k >= 50 && k < 53);
`endif
      @(negedge clk);
      m_grst[k] = bus.pulse_grst;
      m_a[k]    = bus.pulse_a;
      m_d[k]    = bus.pulse_d;
      m_done[k] = bus.done;
      m_busy[k] = bus.busy;
      if (k == 1) begin
        div0_c1 = bus.div0;
        div1_c1 = bus.div1;
      end
      if (k == 16) rep_c16 = bus.rep_cnt;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    rep_end   = bus.rep_cnt;
    div0_end  = bus.div0;
    div1_end  = bus.div1;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b0;
`ifdef MIC4_PULSE_SEQ_TRIG_EN
    ext_trig  = 1'b0;
`endif
    set_cfg(1'b1, 1'b1, 1'b1, 5, 10, 3, 2, 4);

    // Reset held 10 cycles with start high: everything 0.
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_div0", 64'(bus.div0), 64'd0);
    chk("rst_div1", 64'(bus.div1), 64'd0);
    chk("rst_pulses", {61'd0, bus.pulse_grst, bus.pulse_a, bus.pulse_d}, 64'd0);
    chk("rst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("rst_rep_cnt", 64'(bus.rep_cnt), 64'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_start_ignored", 64'(bus.busy), 64'd0);

`ifndef MIC4_PULSE_SEQ_TRIG_EN
    // Full sequence: grst at 9, injections at 15/25/35, done at 36.
    set_cfg(1'b1, 1'b1, 1'b1, 5, 10, 3, 2, 4);
    run_seq(45, -1, -1, -1);
    chk("t2_div0_c1", 64'(div0_c1), 64'd2);
    chk("t2_div1_c1", 64'(div1_c1), 64'd4);
    chk("t2_grst", m_grst, at(9));
    chk("t2_pulse_a", m_a, at(15) | at(25) | at(35));
    chk("t2_pulse_d", m_d, at(15) | at(25) | at(35));
    chk("t2_done", m_done, at(36));
    chk("t2_busy", m_busy, rng(1, 35));
    chk("t2_rep_c16", 64'(rep_c16), 64'd1);
    chk("t2_rep_end", 64'(rep_end), 64'd3);
    chk("t2_div_hold", {52'd0, div0_end, div1_end}, {52'd0, 6'd2, 6'd4});

    // grst only, N=0: grst at 9, done at 10.
    set_cfg(1'b1, 1'b1, 1'b1, 5, 10, 0, 1, 1);
    run_seq(15, -1, -1, -1);
    chk("t3a_grst", m_grst, at(9));
    chk("t3a_inj", m_a | m_d, 64'd0);
    chk("t3a_done", m_done, at(10));
    chk("t3a_busy", m_busy, rng(1, 9));

    // Nothing enabled, N=0: done at 9, no strobes.
    set_cfg(1'b0, 1'b1, 1'b1, 5, 10, 0, 1, 1);
    run_seq(15, -1, -1, -1);
    chk("t3b_strobes", m_grst | m_a | m_d, 64'd0);
    chk("t3b_done", m_done, at(9));
    chk("t3b_busy", m_busy, rng(1, 8));

    // a only, p=0 clamps to spacing 2: pulse_a at 9/11/13/15, done at 16.
    set_cfg(1'b0, 1'b1, 1'b0, 5, 0, 4, 3, 3);
    run_seq(20, -1, -1, -1);
    chk("t4_pulse_a", m_a, at(9) | at(11) | at(13) | at(15));
    chk("t4_pulse_d", m_d, 64'd0);
    chk("t4_done", m_done, at(16));
    chk("t4_rep_c16", 64'(rep_c16), 64'd4);
    chk("t4_busy", m_busy, rng(1, 15));

    // Second start at 12 ignored, abort at 20.
    set_cfg(1'b1, 1'b1, 1'b1, 5, 10, 3, 2, 4);
    run_seq(30, 12, 20, -1);
    chk("t5_grst", m_grst, at(9));
    chk("t5_pulse_a", m_a, at(15));
    chk("t5_pulse_d", m_d, at(15));
    chk("t5_done", m_done, 64'd0);
    chk("t5_busy", m_busy, rng(1, 20));
    chk("t5_rep_end", 64'(rep_end), 64'd1);
    chk("t5_div_hold", 64'(div0_end), 64'd2);

    // start and abort together: nothing launches.
    set_cfg(1'b1, 1'b1, 1'b1, 5, 10, 3, 2, 4);
    run_seq(12, -1, 0, -1);
    chk("t5b_busy", m_busy, 64'd0);
    chk("t5b_strobes", m_grst | m_a | m_d | m_done, 64'd0);

    // Reset mid-sequence at cycle 20 clears everything from cycle 21.
    set_cfg(1'b1, 1'b1, 1'b1, 5, 10, 3, 2, 4);
    run_seq(30, -1, -1, 20);
    chk("rstmid_busy", m_busy, rng(1, 20));
    chk("rstmid_pulse_a", m_a, at(15));
    chk("rstmid_rep", 64'(rep_end), 64'd0);
    chk("rstmid_div", {52'd0, div0_end, div1_end}, 64'd0);
`else
    // Trigger-paced: ext_trig rises at 30 and 50 -> pulse_a at 33 and 53, done at 54.
    set_cfg(1'b0, 1'b1, 1'b0, 5, 10, 2, 2, 4);
    run_seq(60, -1, -1, -1);
    chk("t6_pulse_a", m_a, at(33) | at(53));
    chk("t6_pulse_d", m_d, 64'd0);
    chk("t6_grst", m_grst, 64'd0);
    chk("t6_done", m_done, at(54));
    chk("t6_busy", m_busy, rng(1, 53));
    chk("t6_rep_end", 64'(rep_end), 64'd2);

    // Abort exits WAIT_TRIG: no injections, busy drops at 21.
    set_cfg(1'b0, 1'b1, 1'b0, 5, 10, 2, 2, 4);
    run_seq(40, -1, 20, -1);
    chk("t6_abort_a", m_a, 64'd0);
    chk("t6_abort_busy", m_busy, rng(1, 20));
    chk("t6_abort_done", m_done, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
